// File: rtl/shim_trigger_log_pkg.sv
// shim_trigger_log_pkg: shared state encoding and widths for the trigger log unpacker
package shim_trigger_log_pkg;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LO_PEND = 3'd1,
        S_WAIT_HI = 3'd2,
        S_HI_PEND = 3'd3,
        S_OUT     = 3'd4
    } state_e;
    localparam int TS_W = 64;
    localparam int DELTA_W = 32;
    localparam logic [DELTA_W-1:0] DELTA_SAT = 32'hFFFF_FFFF;
endpackage

// File: rtl/shim_trigger_delta_calc.sv
// shim_trigger_delta_calc: saturated timestamp delta and ordering check against the previous timestamp
module shim_trigger_delta_calc
    import shim_trigger_log_pkg::*;
(
    input  logic [TS_W-1:0]    ts_i,
    input  logic [TS_W-1:0]    prev_i,
    input  logic               first_i,
    output logic [DELTA_W-1:0] delta_o,
    output logic               order_err_o
);
    logic [TS_W-1:0] diff;
    logic order_bad;
    assign diff = ts_i - prev_i;
    assign order_bad = !first_i && (ts_i <= prev_i);
    assign order_err_o = order_bad;
    assign delta_o = (first_i || order_bad) ? '0 :
                     (|diff[TS_W-1:DELTA_W]) ? DELTA_SAT : diff[DELTA_W-1:0];
endmodule

// File: rtl/shim_trigger_log_unpacker.sv
// shim_trigger_log_unpacker: pairs FIFO words into 64-bit timestamps on a valid/ready stream.
// Delta/order tracking is built only when TRIG_LOG_DELTA_EN is defined.
module shim_trigger_log_unpacker
    import shim_trigger_log_pkg::*;
#(
    parameter int PAIR_TIMEOUT = 1024,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    output logic               data_word_rd_en,
    input  logic [31:0]        data_word,
    input  logic               data_buf_empty,
    output logic               ts_valid,
    input  logic               ts_ready,
    output logic [TS_W-1:0]    ts_timestamp,
    output logic [DELTA_W-1:0] ts_delta,
    output logic [CNT_W-1:0]   ts_count,
    output logic               frag_err,
    output logic               order_err
);
    localparam int TW = $clog2(PAIR_TIMEOUT + 1);
    localparam logic [TW-1:0] LAST = TW'(PAIR_TIMEOUT - 1);
    state_e state_q;
    logic [31:0] lo_q;
    logic [TW-1:0] cnt_q;
    logic [TS_W-1:0] ts_q, ts_d;
    logic [CNT_W-1:0] count_q;
    logic valid_q, frag_q;
    assign ts_d = {data_word, lo_q};
    assign data_word_rd_en = resetn && !clear && !data_buf_empty &&
                             (state_q == S_IDLE || state_q == S_LO_PEND || state_q == S_WAIT_HI);
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            cnt_q   <= '0;
            ts_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            frag_q  <= 1'b0;
        end else if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (!data_buf_empty) state_q <= S_LO_PEND;
                S_LO_PEND: begin
                    lo_q <= data_word;
                    cnt_q <= '0;
                    state_q <= data_buf_empty ? S_WAIT_HI : S_HI_PEND;
                end
                S_WAIT_HI: begin
                    if (!data_buf_empty) begin
                        state_q <= S_HI_PEND;
                    end else if (cnt_q == LAST) begin
                        frag_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_HI_PEND: begin
                    ts_q <= ts_d;
                    valid_q <= 1'b1;
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    if (ts_ready) begin
                        valid_q <= 1'b0;
                        count_q <= count_q + 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign ts_valid = valid_q;
    assign ts_timestamp = ts_q;
    assign ts_count = count_q;
    assign frag_err = frag_q;
`ifdef TRIG_LOG_DELTA_EN
    logic [TS_W-1:0] prev_q;
    logic [DELTA_W-1:0] delta_q, delta_d;
    logic first_q, order_q, order_d;
    shim_trigger_delta_calc u_delta (
        .ts_i        (ts_d),
        .prev_i      (prev_q),
        .first_i     (first_q),
        .delta_o     (delta_d),
        .order_err_o (order_d)
    );
    // prev_ts only advances on an accepted handshake, never on a dropped fragment
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_q  <= '0;
            delta_q <= '0;
            first_q <= 1'b1;
            order_q <= 1'b0;
        end else if (clear) begin
            first_q <= 1'b1;
        end else if (state_q == S_HI_PEND) begin
            delta_q <= delta_d;
            order_q <= order_q | order_d;
        end else if (state_q == S_OUT && ts_ready) begin
            prev_q  <= ts_q;
            first_q <= 1'b0;
        end
    end
    assign ts_delta = delta_q;
    assign order_err = order_q;
`else
    assign ts_delta = '0;
    assign order_err = 1'b0;
`endif
endmodule
